// File: rtl/wf_7seg_pkg.sv
// wf_7seg_pkg
//   Shared types and constants for the 7-segment display arbiter.
//   arb_state_e : arbiter FSM state encoding
//   bcd_t       : one BCD digit
//   COLON_*     : colon codes understood by the serial display interface
//   *_DEF       : what the display shows while nobody owns it
package wf_7seg_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

   typedef logic [3:0] bcd_t;

   localparam logic [1:0] COLON_ON   = 2'b00;
   localparam logic [1:0] COLON_DP   = 2'b01;
   localparam logic [1:0] COLON_NONE = 2'b11;

   localparam logic [15:0] IDLE_DIGITS_DEF = 16'h0000;
   localparam logic [1:0]  IDLE_COLON_DEF  = COLON_NONE;

   // owner index width; covers up to 8 requesters
   localparam int OWNER_W = 3;

endpackage

// File: rtl/wf_rr_picker.sv
// wf_rr_picker
//   Combinational round-robin search: first set bit of cand at or after
//   rr_ptr, wrapping around NUM_REQ.
//   cand   in  NUM_REQ  eligible requests
//   rr_ptr in  3        search start index (always < NUM_REQ)
//   valid  out 1        some candidate found
//   idx    out 3        index of the chosen candidate
module wf_rr_picker
   import wf_7seg_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] cand,
   input  logic [OWNER_W-1:0] rr_ptr,
   output logic               valid,
   output logic [OWNER_W-1:0] idx
);

   localparam logic [OWNER_W:0] N_C = (OWNER_W+1)'(NUM_REQ);

   logic [NUM_REQ-1:0] rot;
   logic [OWNER_W:0]   sum;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sum   = '0;
      // rotate so bit 0 is the requester at rr_ptr
      rot   = NUM_REQ'({cand, cand} >> rr_ptr);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!valid && rot[i]) begin
            valid = 1'b1;
            sum   = {1'b0, rr_ptr} + (OWNER_W+1)'(i);
            if (sum >= N_C) sum = sum - N_C;
            idx   = sum[OWNER_W-1:0];
         end
      end
   end

endmodule

// File: rtl/wf_7seg_display_arbiter.sv
// wf_7seg_display_arbiter
//   Shares one 4-digit serial 7-seg display between NUM_REQ requesters with a
//   req/gnt handshake, round-robin fairness and a minimum on-screen hold
//   counted in display scan ticks.
//   clk, rst_n        system clock, async active-low reset
//   tick_en           1-clk scan tick pulse
//   req               level requests
//   digits_in         16 bits per requester, LSD in low nibble
//   colon_in          2 bits per requester
//   gnt/owner/busy    registered grant, owner index, display owned
//   digit0..3, colon  registered data to the display interface
//   Build option WF_7SEG_ARB_TIMEOUT_EN: an owner held for MAX_HOLD ticks is
//   revoked when someone else is waiting, and is masked from arbitration
//   until it drops req for at least one clock.
//
//   state    | meaning
//   ST_IDLE  | no owner; outputs hold until the next tick, then show idle
//   ST_OWNED | owner's data mirrored to the display; min hold enforced
module wf_7seg_display_arbiter
   import wf_7seg_pkg::*;
#(
   parameter int          NUM_REQ     = 4,
   parameter int          MIN_HOLD    = 250,
   parameter int          MAX_HOLD    = 2500,
   parameter logic [15:0] IDLE_DIGITS = IDLE_DIGITS_DEF,
   parameter logic [1:0]  IDLE_COLON  = IDLE_COLON_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tick_en,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [16*NUM_REQ-1:0]  digits_in,
   input  logic [2*NUM_REQ-1:0]   colon_in,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [OWNER_W-1:0]     owner,
   output logic                   busy,
   output bcd_t                   digit0,
   output bcd_t                   digit1,
   output bcd_t                   digit2,
   output bcd_t                   digit3,
   output logic [1:0]             colon
);

   localparam int                   HOLD_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0]    MIN_HOLD_C = HOLD_W'(MIN_HOLD);
   localparam logic [HOLD_W-1:0]    MAX_HOLD_C = HOLD_W'(MAX_HOLD);
   localparam logic [OWNER_W-1:0]   LAST_IDX   = OWNER_W'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [OWNER_W-1:0]  owner_q, owner_d;
   logic [OWNER_W-1:0]  rr_q, rr_d;
   logic [15:0]         digits_q, digits_d;
   logic [1:0]          colon_q, colon_d;
   logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;

   logic [NUM_REQ-1:0]  cand;
   logic                pick_valid;
   logic [OWNER_W-1:0]  pick_idx;
   logic                own_req;
   logic [15:0]         own_digits;
   logic [1:0]          own_colon;
   logic                revoke;

   wf_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .cand   (cand),
      .rr_ptr (rr_q),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   always_comb begin
      own_req    = 1'b0;
      own_digits = '0;
      own_colon  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == OWNER_W'(i)) begin
            own_req    = req[i];
            own_digits = digits_in[16*i +: 16];
            own_colon  = colon_in[2*i +: 2];
         end
      end
   end

   // tick-adjusted hold so a tick landing with the owner's drop releases on that edge
   assign hold_inc = (tick_en && (hold_q < MIN_HOLD_C)) ? hold_q + HOLD_W'(1) : hold_q;

`ifdef WF_7SEG_ARB_TIMEOUT_EN
   logic [NUM_REQ-1:0] mask_q, mask_d;
   logic [HOLD_W-1:0]  age_q, age_d, age_inc;

   assign cand    = req & ~mask_q;
   assign age_inc = (tick_en && (age_q < MAX_HOLD_C)) ? age_q + HOLD_W'(1) : age_q;
   // gnt_q is the owner's one-hot, so req & ~gnt_q are the competitors
   assign revoke  = (state_q == ST_OWNED) && (age_inc >= MAX_HOLD_C) && (|(req & ~gnt_q));

   always_comb begin
      mask_d = mask_q & req;
      if (revoke) mask_d = mask_d | gnt_q;
      age_d  = (state_q == ST_OWNED) ? age_inc : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         age_q  <= '0;
      end else begin
         mask_q <= mask_d;
         age_q  <= age_d;
      end
   end
`else
   assign cand   = req;
   assign revoke = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      digits_d = digits_q;
      colon_d  = colon_q;
      hold_d   = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_OWNED;
               owner_d = pick_idx;
               gnt_d   = NUM_REQ'(1) << pick_idx;
               hold_d  = '0;
            end else if (tick_en) begin
               digits_d = IDLE_DIGITS;
               colon_d  = IDLE_COLON;
            end
         end
         ST_OWNED: begin
            hold_d = hold_inc;
            if (own_req) begin
               digits_d = own_digits;
               colon_d  = own_colon;
            end
            if ((!own_req && (hold_inc >= MIN_HOLD_C)) || revoke) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         rr_q     <= '0;
         digits_q <= IDLE_DIGITS;
         colon_q  <= IDLE_COLON;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         digits_q <= digits_d;
         colon_q  <= colon_d;
         hold_q   <= hold_d;
      end
   end

   assign gnt    = gnt_q;
   assign owner  = owner_q;
   assign busy   = (state_q == ST_OWNED);
   assign digit0 = digits_q[3:0];
   assign digit1 = digits_q[7:4];
   assign digit2 = digits_q[11:8];
   assign digit3 = digits_q[15:12];
   assign colon  = colon_q;

endmodule

// File: tb/tb_wf_7seg_display_arbiter.sv
// Directed bench for wf_7seg_display_arbiter (NUM_REQ=4, MIN_HOLD=3, MAX_HOLD=6,
// tick_en every 10 clocks). Inputs change 1 time unit after the rising edge,
// outputs are sampled at the same point.
module tb_wf_7seg_display_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int MIN_HOLD = 3;
   localparam int MAX_HOLD = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_en = 1'b0;
   logic [3:0]  req = '0;
   logic [63:0] digits_in = '0;
   logic [7:0]  colon_in = '0;
   logic [3:0]  gnt;
   logic [2:0]  owner;
   logic        busy;
   logic [3:0]  digit0, digit1, digit2, digit3;
   logic [1:0]  colon;

   int tests = 0;
   int fails = 0;
   int phase = 0;
   bit last_tick = 1'b0;

   always #5 clk = ~clk;

   wf_7seg_display_arbiter #(
      .NUM_REQ(NUM_REQ), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD),
      .IDLE_DIGITS(16'h0000), .IDLE_COLON(2'b11)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .req(req),
      .digits_in(digits_in), .colon_in(colon_in),
      .gnt(gnt), .owner(owner), .busy(busy),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .colon(colon)
   );

   function automatic logic [15:0] shown();
      return {digit3, digit2, digit1, digit0};
   endfunction

   // one clock edge; tick_en is high for the edge when phase == 9
   task automatic step();
      tick_en   = (phase == 9);
      last_tick = tick_en;
      phase     = (phase == 9) ? 0 : phase + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic step_to_tick();
      for (int i = 0; i < 10; i++) begin
         step();
         if (last_tick) break;
      end
   endtask

   // advance until the next step() carries a tick
   task automatic until_tick_next();
      for (int i = 0; i < 10; i++) begin
         if (phase == 9) break;
         step();
      end
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (3) step();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (owner !== 3'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", owner); end
      tests++; if (shown() !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h want 0000", shown()); end
      tests++; if (colon !== 2'b11) begin fails++; $display("FAIL reset_colon: got %b want 11", colon); end
      rst_n = 1'b1;
      step();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL idle_no_req: got %b want 0000", gnt); end
      req = 4'b0001;
      step();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL pre_async_gnt: got %b want 0001", gnt); end
      #1 rst_n = 1'b0;
      #1;
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL async_reset_gnt: got %b want 0000", gnt); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      req   = '0;
   endtask

   task automatic test_single_grant();
      step_to_tick();
      digits_in[15:0] = 16'h1234;
      colon_in[1:0]   = 2'b01;
      req = 4'b0001;
      step();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL grant_latency: got %b want 0001", gnt); end
      tests++; if (busy !== 1'b1 || owner !== 3'd0) begin fails++; $display("FAIL grant_owner: busy=%b owner=%0d want 1/0", busy, owner); end
      tests++; if (shown() !== 16'h0000) begin fails++; $display("FAIL digits_early: got %h want 0000", shown()); end
      step();
      tests++; if (shown() !== 16'h1234) begin fails++; $display("FAIL digits_capture: got %h want 1234", shown()); end
      tests++; if (colon !== 2'b01) begin fails++; $display("FAIL colon_capture: got %b want 01", colon); end
   endtask

   task automatic test_min_hold();
      step_to_tick();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL hold_tick1: got %b want 0001", gnt); end
      req = 4'b0000;
      digits_in[15:0] = 16'h5678;
      colon_in[1:0]   = 2'b00;
      step_to_tick();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL hold_tick2: got %b want 0001", gnt); end
      tests++; if (shown() !== 16'h1234 || colon !== 2'b01) begin fails++; $display("FAIL hold_frozen: got %h/%b want 1234/01", shown(), colon); end
      until_tick_next();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL hold_before_tick3: got %b want 0001", gnt); end
      step();
      tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL hold_release: gnt=%b busy=%b want 0000/0", gnt, busy); end
      step();
      tests++; if (shown() !== 16'h1234) begin fails++; $display("FAIL idle_hold_last: got %h want 1234", shown()); end
      step_to_tick();
      tests++; if (shown() !== 16'h0000 || colon !== 2'b11) begin fails++; $display("FAIL idle_load: got %h/%b want 0000/11", shown(), colon); end
   endtask

   task automatic test_round_robin();
      int          order [4];
      logic [15:0] dig [4];
      order = '{0, 1, 3, 0};
      dig   = '{16'h0101, 16'h2222, 16'h3333, 16'h4444};
      do_reset();
      step_to_tick();
      digits_in = {dig[3], dig[2], dig[1], dig[0]};
      colon_in  = 8'b00_11_01_00;
      req = 4'b1011;
      for (int r = 0; r < 4; r++) begin
         int k;
         k = order[r];
         step();
         tests++; if (gnt !== 4'(1 << k) || owner !== 3'(k)) begin fails++; $display("FAIL rr_grant%0d: gnt=%b owner=%0d want owner %0d", r, gnt, owner, k); end
         step();
         tests++; if (shown() !== dig[k]) begin fails++; $display("FAIL rr_digits%0d: got %h want %h", r, shown(), dig[k]); end
         repeat (3) step_to_tick();
         tests++; if (gnt !== 4'(1 << k)) begin fails++; $display("FAIL rr_hold%0d: got %b want %b", r, gnt, 4'(1 << k)); end
         req[k] = 1'b0;
         step();
         tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL rr_release%0d: gnt=%b busy=%b want 0000/0", r, gnt, busy); end
         req[k] = 1'b1;
      end
      req = '0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      step_to_tick();
      digits_in[15:0] = 16'h9876;
      req = 4'b0001;
      step();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL sim_grant: got %b want 0001", gnt); end
      step_to_tick();
      step_to_tick();
      until_tick_next();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL sim_pre_edge: got %b want 0001", gnt); end
      req = 4'b0000;
      step();
      tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL sim_release_edge: gnt=%b busy=%b want 0000/0", gnt, busy); end
   endtask

   task automatic test_reraise();
      step_to_tick();
      digits_in[31:16] = 16'h2468;
      colon_in[3:2]    = 2'b01;
      req = 4'b0010;
      step();
      tests++; if (gnt !== 4'b0010 || owner !== 3'd1) begin fails++; $display("FAIL rer_grant: gnt=%b owner=%0d want 0010/1", gnt, owner); end
      step();
      tests++; if (shown() !== 16'h2468) begin fails++; $display("FAIL rer_digits: got %h want 2468", shown()); end
      req = 4'b0000;
      digits_in[31:16] = 16'h1357;
      step();
      step();
      tests++; if (gnt !== 4'b0010 || shown() !== 16'h2468) begin fails++; $display("FAIL rer_dropped: gnt=%b dig=%h want 0010/2468", gnt, shown()); end
      req = 4'b0011;
      step();
      step();
      tests++; if (gnt !== 4'b0010 || shown() !== 16'h1357) begin fails++; $display("FAIL rer_continue: gnt=%b dig=%h want 0010/1357", gnt, shown()); end
      req = 4'b0010;
      step();
      tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rer_other_drop: got %b want 0010", gnt); end
      req = 4'b0000;
      repeat (3) step_to_tick();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rer_final_release: got %b want 0000", gnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      step_to_tick();
      digits_in[15:0]  = 16'h0606;
      digits_in[47:32] = 16'h3030;
      req = 4'b0001;
      step();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL to_grant0: got %b want 0001", gnt); end
      req = 4'b0101;
      repeat (5) step_to_tick();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL to_before_max: got %b want 0001", gnt); end
      step_to_tick();
`ifdef WF_7SEG_ARB_TIMEOUT_EN
      tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL to_revoke: gnt=%b busy=%b want 0000/0", gnt, busy); end
      step();
      tests++; if (gnt !== 4'b0100 || owner !== 3'd2) begin fails++; $display("FAIL to_grant2: gnt=%b owner=%0d want 0100/2", gnt, owner); end
      req = 4'b0001;
      repeat (3) step_to_tick();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL to_masked_release: got %b want 0000", gnt); end
      repeat (3) step();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL to_masked_stay: got %b want 0000", gnt); end
      req = 4'b0000;
      step();
      req = 4'b0001;
      step();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL to_unmasked_grant: got %b want 0001", gnt); end
`else
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL to_no_revoke: got %b want 0001", gnt); end
      repeat (2) step_to_tick();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL to_keep: got %b want 0001", gnt); end
`endif
      req = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_grant();
      test_min_hold();
      test_round_robin();
      test_simultaneous();
      test_reraise();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
